// File: rtl/ibex_sram_arbiter.sv
// Round-robin arbiter: Ibex instruction and data ports onto one single-port SRAM.
// Combinational grant, fixed one-cycle response, out-of-region accesses answered with an error.
module ibex_sram_arbiter #(
  parameter logic [31:0] MemStart = 32'h0000_0000,
  parameter int unsigned MemSize  = 65536
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [31:0] MemMask = 32'(MemSize - 1);

  typedef enum logic {
    HostInstr = 1'b0,
    HostData  = 1'b1
  } host_e;

  host_e       rr_last_q, rr_last_d;
  logic        rsp_vld_q, rsp_vld_d;
  host_e       rsp_owner_q, rsp_owner_d;
  logic        rsp_err_q, rsp_err_d;

  logic        gnt_instr, gnt_data, gnt_any;
  logic [31:0] sel_addr;
  logic        in_region;
  logic [31:0] rsp_rdata;

  // Fixed SRAM latency: the pending record alone decides response timing.
  logic unused_ram_rvalid;
  assign unused_ram_rvalid = ram_rvalid_i;

  // Data wins a conflict unless it was the last host served.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (rst_sys_n) begin
      if (data_req_i && (!instr_req_i || rr_last_q == HostInstr)) begin
        gnt_data = 1'b1;
      end else if (instr_req_i) begin
        gnt_instr = 1'b1;
      end
    end
  end

  assign gnt_any     = gnt_instr | gnt_data;
  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  always_comb begin
    sel_addr    = 32'h0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_wdata_o = 32'h0;
    if (gnt_data) begin
      sel_addr    = data_addr_i;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_wdata_o = data_wdata_i;
    end else if (gnt_instr) begin
      sel_addr    = instr_addr_i;
      ram_be_o    = 4'hF;
    end
  end

  assign in_region  = (sel_addr & ~MemMask) == MemStart;
  assign ram_addr_o = sel_addr;
  assign ram_req_o  = gnt_any & in_region;

  always_comb begin
    rr_last_d   = rr_last_q;
    rsp_vld_d   = gnt_any;
    rsp_owner_d = rsp_owner_q;
    rsp_err_d   = 1'b0;
    if (gnt_data) begin
      rr_last_d   = HostData;
      rsp_owner_d = HostData;
      rsp_err_d   = ~in_region;
    end else if (gnt_instr) begin
      rr_last_d   = HostInstr;
      rsp_owner_d = HostInstr;
      rsp_err_d   = ~in_region;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rr_last_q   <= HostInstr;
      rsp_vld_q   <= 1'b0;
      rsp_owner_q <= HostInstr;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_last_q   <= rr_last_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_rdata = rsp_err_q ? 32'h0 : ram_rdata_i;

  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = 32'h0;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    data_rdata_o   = 32'h0;
    if (rsp_vld_q) begin
      if (rsp_owner_q == HostData) begin
        data_rvalid_o = 1'b1;
        data_err_o    = rsp_err_q;
        data_rdata_o  = rsp_rdata;
      end else begin
        instr_rvalid_o = 1'b1;
        instr_err_o    = rsp_err_q;
        instr_rdata_o  = rsp_rdata;
      end
    end
  end

endmodule
